// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the slide-switch conditioning path.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_TO_HIGH,
    S_HIGH,
    S_TO_LOW
  } db_state_t;

  localparam int CLK_HZ = 100_000_000;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchroniser, debounce FSM and edge pulses.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES clocks pin-to-output; no backpressure.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge_nxt
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_t              r_state;
  db_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_stable_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_LOW;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
    end
  end

  // Any reversal of the synchronised input while qualifying drops back and clears the count.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_stable_nxt = r_stable;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    case (r_state)
      S_LOW: begin
        if (w_s) begin
          w_state_nxt = S_TO_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_TO_HIGH: begin
        if (!w_s) begin
          w_state_nxt = S_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_HIGH;
          w_stable_nxt = 1'b1;
          w_rise_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!w_s) begin
          w_state_nxt = S_TO_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_TO_LOW: begin
        if (w_s) begin
          w_state_nxt = S_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_LOW;
          w_stable_nxt = 1'b0;
          w_fall_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: w_state_nxt = S_LOW;
    endcase
  end

  assign o_stable   = r_stable;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_edge_nxt = w_rise_nxt | w_fall_nxt;

endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW raw slide switches into clean levels plus rise/fall/changed pulses.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES clocks; no backpressure, all outputs registered.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N_SW            = 4,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_changed
);

  if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("sw_debounce: DEBOUNCE_CYCLES and SYNC_STAGES must both be >= 2");
  end

  logic [N_SW-1:0] w_edge_nxt;
  logic            r_changed;

  for (genvar g = 0; g < N_SW; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_raw     (sw_raw[g]),
      .o_stable  (sw_stable[g]),
      .o_rise    (sw_rise[g]),
      .o_fall    (sw_fall[g]),
      .o_edge_nxt(w_edge_nxt[g])
    );
  end

  // Registered from the per-bit next-edge terms so it lands in the same cycle as the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_edge_nxt;
    end
  end

  assign sw_changed = r_changed;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed and randomized checks of sw_debounce against a run-length reference model.
module tb_sw_debounce;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int SYN = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_stable;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic         sw_changed;

  int n_chk = 0;
  int n_err = 0;

  // Reference: s is the pin value seen SYN edges earlier; the level flips after DB
  // consecutive edges on which s differs from it.
  logic [N-1:0] mq[$];
  int           mrun[N];
  logic [N-1:0] m_stable;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;
  logic         m_chg;

  sw_debounce #(
    .N_SW           (N),
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SYN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    mq.delete();
    for (int i = 0; i < SYN; i++) mq.push_back('0);
    for (int b = 0; b < N; b++) mrun[b] = 0;
    m_stable = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_chg    = 1'b0;
  endtask

  task automatic mdl_edge();
    logic [N-1:0] s;
    s = mq.pop_front();
    mq.push_back(sw_raw);
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < N; b++) begin
      if (s[b] != m_stable[b]) begin
        mrun[b]++;
        if (mrun[b] == DB) begin
          m_stable[b] = s[b];
          if (s[b]) m_rise[b] = 1'b1;
          else      m_fall[b] = 1'b1;
          mrun[b] = 0;
        end
      end else begin
        mrun[b] = 0;
      end
    end
    m_chg = |(m_rise | m_fall);
  endtask

  // Drive on the falling edge, advance the model on the rising edge, sample 1 ns later.
  task automatic step(input logic [N-1:0] v, input logic r);
    @(negedge clk);
    sw_raw = v;
    rst_n  = r;
    if (!r) mdl_reset();
    @(posedge clk);
    if (rst_n) mdl_edge();
    #1;
    chk("stable", 32'(sw_stable), 32'(m_stable));
    chk("rise", 32'(sw_rise), 32'(m_rise));
    chk("fall", 32'(sw_fall), 32'(m_fall));
    chk("changed", 32'(sw_changed), 32'(m_chg));
  endtask

  initial begin
    logic [N-1:0] cur;
    logic         r;
    mdl_reset();

    // Reset held with all switches high: every output stays low.
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b0);
      chk("rst_out", {sw_stable, sw_rise, sw_fall, sw_changed}, 32'd0);
    end
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);

    // Clean press on bit 0.
    for (int i = 1; i <= 6; i++) begin
      step(4'b0001, 1'b1);
      chk("press_rise", 32'(sw_rise[0]), (i == 6) ? 32'd1 : 32'd0);
      chk("press_stable", 32'(sw_stable[0]), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("press_chg", 32'(sw_changed), 32'd1);
    step(4'b0001, 1'b1);
    chk("press_pulse_end", 32'(sw_rise[0]), 32'd0);

    // Bounce on bit 1, then settle high.
    step(4'b0011, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0001, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step(4'b0011, 1'b1);
      chk("bounce_rise", 32'(sw_rise[1]), (i == 6) ? 32'd1 : 32'd0);
    end

    // Three-cycle glitch on bit 2 is rejected.
    for (int i = 0; i < 3; i++) step(4'b0111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'b0011, 1'b1);
      chk("glitch_stable", 32'(sw_stable[2]), 32'd0);
      chk("glitch_rise", 32'(sw_rise[2]), 32'd0);
    end

    // Settle at 0001, then swap every bit at once.
    for (int i = 0; i < 8; i++) step(4'b0001, 1'b1);
    chk("pre_swap", 32'(sw_stable), 32'h1);
    for (int i = 0; i < 6; i++) step(4'b1110, 1'b1);
    chk("swap_fall", 32'(sw_fall), 32'h1);
    chk("swap_rise", 32'(sw_rise), 32'hE);
    chk("swap_chg", 32'(sw_changed), 32'd1);
    chk("swap_stable", 32'(sw_stable), 32'hE);

    // Reset mid-qualification of bit 3 with the pin held high through it.
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b1000, 1'b0);
      chk("midrst_out", {sw_stable, sw_rise, sw_fall, sw_changed}, 32'd0);
    end
    for (int i = 1; i <= 6; i++) begin
      step(4'b1000, 1'b1);
      chk("midrst_rise", 32'(sw_rise[3]), (i == 6) ? 32'd1 : 32'd0);
    end

    // Randomized toggling with occasional resets.
    cur = 4'b1000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      r = ($urandom_range(0, 499) != 0);
      step(cur, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
